// File: rtl/tdm_demux.sv
// ============================================================================
// tdm_demux : serial TDM receiver. It locks to fsync, collects one slot per
// clock and presents each completed frame on registered outputs.
// Optional build macro: TDM_DEMUX_PARITY_EN (adds an even-parity slot).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tdm_demux #(
  parameter int CHANNELS = 4
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                din,
  input  logic                fsync,
  output logic [CHANNELS-1:0] dout,
  output logic                frame_valid,
  output logic                locked,
  output logic                sync_err,
  output logic                parity_err
);

  localparam int c_cnt_w = $clog2(CHANNELS + 1);
`ifdef TDM_DEMUX_PARITY_EN
  localparam int c_frame_len = CHANNELS + 1;
`else
  localparam int c_frame_len = CHANNELS;
`endif
  // Every slot except the last is held here; the last slot is used straight from din.
  localparam int                 c_shadow_w = c_frame_len - 1;
  localparam logic [c_cnt_w-1:0] c_last     = c_cnt_w'(c_frame_len - 1);
  localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [c_cnt_w-1:0]    r_cnt, w_cnt_nxt;
  logic [c_shadow_w-1:0] r_shadow, w_shadow_nxt;
  logic [CHANNELS-1:0]   w_dout_nxt;
  logic                  w_fv_nxt, w_serr_nxt, w_perr_nxt;
  logic [CHANNELS-1:0]   w_frame;
  logic                  w_frame_ok;

`ifdef TDM_DEMUX_PARITY_EN
  assign w_frame    = r_shadow;
  assign w_frame_ok = ~(^{din, r_shadow});
`else
  assign w_frame    = {din, r_shadow};
  assign w_frame_ok = 1'b1;
`endif

  assign locked = (r_state == LOCKED);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
    w_dout_nxt   = dout;
    w_fv_nxt     = 1'b0;
    w_serr_nxt   = 1'b0;
    w_perr_nxt   = 1'b0;
    case (r_state)
      HUNT: begin
        if (fsync) begin
          w_shadow_nxt[0] = din;
          w_cnt_nxt       = c_one;
          w_state_nxt     = LOCKED;
        end
      end
      LOCKED: begin
        if (fsync) begin
          // A strobe anywhere but slot 0 restarts the frame at this cycle.
          w_serr_nxt      = (r_cnt != '0);
          w_shadow_nxt[0] = din;
          w_cnt_nxt       = c_one;
        end else if (r_cnt == '0) begin
          w_serr_nxt  = 1'b1;
          w_state_nxt = HUNT;
        end else if (r_cnt == c_last) begin
          w_cnt_nxt = '0;
          if (w_frame_ok) begin
            w_dout_nxt = w_frame;
            w_fv_nxt   = 1'b1;
          end else begin
            w_perr_nxt = 1'b1;
          end
        end else begin
          for (int k = 1; k < c_shadow_w; k++) begin
            if (r_cnt == c_cnt_w'(k)) w_shadow_nxt[k] = din;
          end
          w_cnt_nxt = r_cnt + c_one;
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= HUNT;
      r_cnt       <= '0;
      r_shadow    <= '0;
      dout        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      parity_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shadow    <= w_shadow_nxt;
      dout        <= w_dout_nxt;
      frame_valid <= w_fv_nxt;
      sync_err    <= w_serr_nxt;
      parity_err  <= w_perr_nxt;
    end
  end

endmodule

`default_nettype wire
